// File: rtl/enigma_step_ctrl_if.sv
// Handshake bundle for the Enigma rotor-stepping controller.
// Handshake rule (both sides): a transfer happens on a rising edge where
// valid and ready are both high; the sender holds its payload steady while
// valid is high and ready is low.
interface enigma_step_ctrl_if;
    logic       load;
    logic [4:0] load_pos0;
    logic [4:0] load_pos1;
    logic [4:0] load_pos2;
    logic       key_valid;
    logic [4:0] key_in;
    logic       key_ready;
    logic [4:0] letter_out;
    logic [4:0] pos0;
    logic [4:0] pos1;
    logic [4:0] pos2;
    logic       letter_valid;
    logic       letter_ready;
    logic       key_err;

    // Environment view: supplies keys/loads, consumes stepped letters.
    modport master (
        output load, load_pos0, load_pos1, load_pos2,
        output key_valid, key_in, letter_ready,
        input  key_ready, letter_out, pos0, pos1, pos2, letter_valid, key_err
    );

    // Controller view.
    modport slave (
        input  load, load_pos0, load_pos1, load_pos2,
        input  key_valid, key_in, letter_ready,
        output key_ready, letter_out, pos0, pos1, pos2, letter_valid, key_err
    );
endinterface

// File: rtl/enigma_step_ctrl.sv
// Enigma rotor-stepping front end: accepts one letter, steps the three
// rotors with odometer rules (including the middle-rotor double step) and
// presents letter plus stepped positions downstream until accepted.
module enigma_step_ctrl #(
    parameter int NOTCH0 = 16,
    parameter int NOTCH1 = 4
) (
    input  logic               clk,
    input  logic               rst,
    enigma_step_ctrl_if.slave  bus,
    output logic [1:0]         state_dbg
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_STEP  = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;

    localparam logic [4:0] NOTCH0_L = 5'(NOTCH0);
    localparam logic [4:0] NOTCH1_L = 5'(NOTCH1);

    logic [1:0] state_q, state_d;
    logic [4:0] pos0_q, pos0_d;
    logic [4:0] pos1_q, pos1_d;
    logic [4:0] pos2_q, pos2_d;
    logic [4:0] letter_q, letter_d;
    logic       letter_valid_q, letter_valid_d;
    logic       key_err_q, key_err_d;

    // Load values 26..31 fold back onto 0..5.
    function automatic logic [4:0] mod26(input logic [4:0] v);
        return (v >= 5'd26) ? (v - 5'd26) : v;
    endfunction

    // One rotor position forward, wrapping 25 -> 0.
    function automatic logic [4:0] inc26(input logic [4:0] v);
        return (v == 5'd25) ? 5'd0 : (v + 5'd1);
    endfunction

    // Load has priority over a key; keys are only taken while idle.
    assign bus.key_ready = (state_q == ST_IDLE) && !bus.load;

    // Next-state and datapath update for the IDLE/STEP/ISSUE sequence.
    always_comb begin
        state_d        = state_q;
        pos0_d         = pos0_q;
        pos1_d         = pos1_q;
        pos2_d         = pos2_q;
        letter_d       = letter_q;
        letter_valid_d = letter_valid_q;
        key_err_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.load) begin
                    pos0_d = mod26(bus.load_pos0);
                    pos1_d = mod26(bus.load_pos1);
                    pos2_d = mod26(bus.load_pos2);
                end else if (bus.key_valid) begin
                    if (bus.key_in <= 5'd25) begin
                        letter_d = bus.key_in;
                        state_d  = ST_STEP;
                    end else begin
                        // Illegal letter is consumed and flagged, nothing steps.
                        key_err_d = 1'b1;
                    end
                end
            end
            ST_STEP: begin
                // All decisions use the pre-step positions.
                pos0_d = inc26(pos0_q);
                if ((pos0_q == NOTCH0_L) || (pos1_q == NOTCH1_L)) begin
                    pos1_d = inc26(pos1_q);
                end
                if (pos1_q == NOTCH1_L) begin
                    pos2_d = inc26(pos2_q);
                end
                letter_valid_d = 1'b1;
                state_d        = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (bus.letter_ready) begin
                    letter_valid_d = 1'b0;
                    state_d        = ST_IDLE;
                end
            end
            default: begin
                letter_valid_d = 1'b0;
                state_d        = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            pos0_q         <= 5'd0;
            pos1_q         <= 5'd0;
            pos2_q         <= 5'd0;
            letter_q       <= 5'd0;
            letter_valid_q <= 1'b0;
            key_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            pos0_q         <= pos0_d;
            pos1_q         <= pos1_d;
            pos2_q         <= pos2_d;
            letter_q       <= letter_d;
            letter_valid_q <= letter_valid_d;
            key_err_q      <= key_err_d;
        end
    end

    assign bus.pos0         = pos0_q;
    assign bus.pos1         = pos1_q;
    assign bus.pos2         = pos2_q;
    assign bus.letter_out   = letter_q;
    assign bus.letter_valid = letter_valid_q;
    assign bus.key_err      = key_err_q;
    assign state_dbg        = state_q;
endmodule

// File: doc/enigma_step_ctrl.md
# enigma_step_ctrl

Rotor-stepping front end for the Enigma datapath. Accepts one plaintext letter at a time over a valid/ready handshake. Advances the three rotor positions using Enigma odometer rules, including the middle-rotor double step. Presents the letter plus the stepped positions to the downstream rotor/reflector substitution stage, holding them stable until that stage accepts.

## Interface
Parameters:
- NOTCH0, default 16: position of the fast rotor (rotor 0) at which the middle rotor is carried.
- NOTCH1, default 4: position of the middle rotor (rotor 1) at which the left rotor is carried and the middle rotor double-steps.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  load initial rotor positions (honoured only in IDLE).
- load_pos0, load_pos1, load_pos2  in  5 each  initial positions for rotors 0/1/2.
- key_valid  in  1  key_in is valid.
- key_in  in  5  letter code; 0..25 are legal.
- key_ready  out  1  controller can accept a key this cycle.
- letter_out  out  5  registered accepted letter.
- pos0, pos1, pos2  out  5 each  registered rotor positions, always 0..25.
- letter_valid  out  1  letter_out and pos0..2 are valid for downstream.
- letter_ready  in  1  downstream accepts.
- key_err  out  1  one-cycle pulse: an illegal key (>25) was dropped.

## Operation
- States: IDLE, STEP, ISSUE. After reset the state is IDLE.
- Reset values: pos0/1/2 = 0, letter_out = 0, letter_valid = 0, key_err = 0.
- key_ready = (state == IDLE) && !load. It is combinational from state and load.
- **Load:** in IDLE with load = 1, each posN ← load_posN, reduced mod 26 (values 26..31 become 0..5). State stays IDLE.
  - Load is ignored in STEP and ISSUE.
  - If load and key_valid are both high in the same cycle, load wins and the key is not accepted.
- **Key accept:** in IDLE, key_valid && key_ready.
  - If key_in ≤ 25: letter_out ← key_in, go to STEP.
  - If key_in > 25: the key is consumed and dropped. key_err = 1 for the next cycle, positions are unchanged, and the state stays IDLE.
- **STEP** (one cycle), evaluated on the pre-step values:
  - pos0 always increments.
  - pos1 increments if pos0 == NOTCH0 or pos1 == NOTCH1 (double step).
  - pos2 increments if pos1 == NOTCH1.
  - Every increment wraps 25 → 0.
  - Then go to ISSUE.
- **ISSUE:** letter_valid = 1.
  - letter_out and pos0..2 are held constant while letter_valid && !letter_ready.
  - On letter_ready: letter_valid ← 0, go to IDLE.
- **Reset mid-operation:** rst in STEP or ISSUE returns to IDLE with the reset values above. Any in-flight letter is discarded.

## Timing
- Key accepted at edge N → positions updated at edge N+1 → letter_valid high from edge N+1.
- Downstream therefore sees the new positions in the same cycle letter_valid first rises.
- With letter_ready tied high: letter_valid is high for exactly one cycle, and key_ready returns high the cycle after the handshake. Throughput is one letter per 3 cycles.
- letter_ready is ignored when letter_valid = 0.
- key_err pulses for exactly one cycle, the cycle after the illegal key is accepted.
- Load takes effect at the edge where it is sampled. The new positions are visible on the next cycle.
- All outputs except key_ready are registered.

## Test plan
- **Reset/idle:** assert rst 2 cycles → pos0/1/2 = 0, letter_valid = 0, key_err = 0, key_ready = 1.
- **Plain step:** load (0,0,0), key 7, letter_ready = 1 → letter_valid for 1 cycle 2 edges after accept, letter_out = 7, positions (1,0,0). Ten further keys → pos0 = 11, pos1 = pos2 = 0.
- **Carry and double step** (default notches): load (16,3,0), key 0 → (17,4,0). Next key → (18,5,1), the double step. Next key → (19,5,1).
- **Wrap:** load (25,25,25), key 1 → (0,25,25). Load (16,25,3), key 2 → (17,0,3).
- **Backpressure and illegal input:**
  - Hold letter_ready = 0 for 5 cycles in ISSUE → letter_out/pos stable, key_ready = 0, a key_valid pulse with key 3 is not accepted. Release → single handshake.
  - Key 28 in IDLE → key_err pulse, no letter_valid, positions unchanged.
- **Conflicts and reset:**
  - load with key_valid in the same cycle → load applied, key not taken.
  - Load (30,0,0) → pos0 = 4.
  - rst during ISSUE → letter_valid = 0 and positions 0 the next cycle.
